// File: rtl/sequence_pattern_generator.sv
// rtl/sequence_pattern_generator.sv - serial MSB-first pattern transmitter with repeat and gap
//
// Drives the serial sequence_in line of the sequence detector. A pattern word
// is captured on a valid/ready handshake and shifted out one bit per clock,
// highest used bit first, load_repeat+1 times with GAP idle cycles between
// repetitions. done pulses for one cycle when the last repetition finishes.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   load_valid   request to start a pattern
//   load_ready   high while idle; load accepted on load_valid && load_ready && !abort
//   load_data    pattern bits, bit [len-1] sent first
//   load_len     bits per repetition, clamped to MAX_LEN
//   load_repeat  extra repetitions (pattern sent load_repeat+1 times)
//   abort        synchronous cancel, highest priority after reset
//   sequence_out registered serial data, IDLE_LEVEL when no bit is sent
//   out_valid    registered, high while sequence_out carries a pattern bit
//   done         registered one-cycle completion pulse
module sequence_pattern_generator #(
    parameter int   MAX_LEN    = 16,
    parameter int   LEN_W      = 5,
    parameter int   REP_W      = 4,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [REP_W-1:0]   load_repeat,
    input  logic               abort,
    output logic               sequence_out,
    output logic               out_valid,
    output logic               done
);

    localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [IDX_W-1:0]   last_q, last_d;     // index of the first bit sent (len-1)
    logic [IDX_W-1:0]   idx_q, idx_d;       // index of the bit currently on sequence_out
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               seq_q, seq_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   eff_len;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   idx_dec;

    assign eff_len   = (load_len > MAX_LEN_L) ? MAX_LEN_L : load_len;
    assign first_idx = IDX_W'(eff_len - LEN_W'(1));
    assign idx_dec   = idx_q - IDX_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            seq_q   <= IDLE_LEVEL;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        seq_d   = IDLE_LEVEL;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_valid) begin
                        data_d = load_data;
                        rep_d  = load_repeat;
                        if (eff_len == '0) begin
                            // Empty pattern: nothing to send, complete immediately.
                            done_d = 1'b1;
                        end else begin
                            state_d = S_SHIFT;
                            last_d  = first_idx;
                            idx_d   = first_idx;
                            seq_d   = load_data[first_idx];
                            valid_d = 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (idx_q != '0) begin
                        idx_d   = idx_dec;
                        seq_d   = data_q[idx_dec];
                        valid_d = 1'b1;
                    end else if (rep_q != '0) begin
                        rep_d = rep_q - REP_W'(1);
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = GAP_W'(GAP_LAST);
                        end else begin
                            // No gap: the next repetition's first bit follows without a bubble.
                            idx_d   = last_q;
                            seq_d   = data_q[last_q];
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end

                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_SHIFT;
                        idx_d   = last_q;
                        seq_d   = data_q[last_q];
                        valid_d = 1'b1;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign load_ready   = (state_q == S_IDLE);
    assign sequence_out = seq_q;
    assign out_valid    = valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// tb/tb_sequence_pattern_generator.sv - self-checking bench for sequence_pattern_generator
module tb_sequence_pattern_generator;

    logic        clock;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic [4:0]  load_len;
    logic [3:0]  load_repeat;
    logic        abort;

    logic g_ready, g_seq, g_valid, g_done;
    logic n_ready, n_seq, n_valid, n_done;

    int total;
    int bad;
    int rl_g, vh_g, rl_n, vh_n;

    typedef struct packed {
        logic v;
        logic b;
        logic d;
        logic r;
    } exp_t;

    exp_t exp_g[$];
    exp_t exp_n[$];

    sequence_pattern_generator #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP(2), .IDLE_LEVEL(1'b0)) dut_g (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(g_ready),
        .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat), .abort(abort),
        .sequence_out(g_seq), .out_valid(g_valid), .done(g_done)
    );

    sequence_pattern_generator #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP(0), .IDLE_LEVEL(1'b0)) dut_n (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(n_ready),
        .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat), .abort(abort),
        .sequence_out(n_seq), .out_valid(n_valid), .done(n_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push_exp(input int gap, input exp_t e);
        if (gap == 2) exp_g.push_back(e);
        else exp_n.push_back(e);
    endtask

    // Expected cycle-by-cycle stream after the acceptance edge, built from the
    // pattern description: bits MSB-first, gaps between repetitions, then done.
    task automatic model_push(input int gap, input logic [15:0] d, input int len, input int rep);
        int   eff;
        exp_t e;
        eff = (len > 16) ? 16 : len;
        if (eff == 0) begin
            e = '{1'b0, 1'b0, 1'b1, 1'b1};
            push_exp(gap, e);
            return;
        end
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < eff; i++) begin
                e = '{1'b1, d[eff-1-i], 1'b0, 1'b0};
                push_exp(gap, e);
            end
            if (r < rep) begin
                for (int k = 0; k < gap; k++) begin
                    e = '{1'b0, 1'b0, 1'b0, 1'b0};
                    push_exp(gap, e);
                end
            end
        end
        e = '{1'b0, 1'b0, 1'b1, 1'b1};
        push_exp(gap, e);
    endtask

    task automatic start(input logic [15:0] d, input int len, input int rep);
        load_data   = d;
        load_len    = 5'(len);
        load_repeat = 4'(rep);
        load_valid  = 1'b1;
        @(posedge clock);
        #1;
        model_push(2, d, len, rep);
        model_push(0, d, len, rep);
    endtask

    task automatic check_streams(input string name, input int drop_at);
        int n;
        rl_g = 0; vh_g = 0; rl_n = 0; vh_n = 0;
        n = ((exp_g.size() > exp_n.size()) ? exp_g.size() : exp_n.size()) + 1;
        for (int j = 0; j < n; j++) begin
            exp_t eg;
            exp_t en;
            eg = (exp_g.size() > 0) ? exp_g.pop_front() : exp_t'(4'b0001);
            en = (exp_n.size() > 0) ? exp_n.pop_front() : exp_t'(4'b0001);
            total++;
            if ({g_valid, g_seq, g_done, g_ready} !== eg) begin
                bad++;
                $display("FAIL %s gap2 cyc%0d {valid,seq,done,ready} got=%b want=%b",
                         name, j, {g_valid, g_seq, g_done, g_ready}, eg);
            end
            total++;
            if ({n_valid, n_seq, n_done, n_ready} !== en) begin
                bad++;
                $display("FAIL %s gap0 cyc%0d {valid,seq,done,ready} got=%b want=%b",
                         name, j, {n_valid, n_seq, n_done, n_ready}, en);
            end
            if (!g_ready) rl_g++;
            if (g_valid)  vh_g++;
            if (!n_ready) rl_n++;
            if (n_valid)  vh_n++;
            if (j == drop_at) begin
                // Inputs change after acceptance; the transmission must not notice.
                load_valid  = 1'b0;
                load_data   = 16'($urandom);
                load_len    = 5'($urandom);
                load_repeat = 4'($urandom);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({g_valid, g_seq, g_done, g_ready} !== 4'b0001 || {n_valid, n_seq, n_done, n_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_hold got g=%b n=%b want=0001",
                     {g_valid, g_seq, g_done, g_ready}, {n_valid, n_seq, n_done, n_ready});
        end
        reset = 1'b0;
        start(16'h00FF, 8, 0);
        exp_g.delete();
        exp_n.delete();
        load_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        total++;
        if (g_valid !== 1'b1 || g_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_pre_shift valid=%b ready=%b want valid=1 ready=0", g_valid, g_ready);
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({g_valid, g_seq, g_done, g_ready} !== 4'b0001 || {n_valid, n_seq, n_done, n_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_async got g=%b n=%b want=0001",
                     {g_valid, g_seq, g_done, g_ready}, {n_valid, n_seq, n_done, n_ready});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        start(16'h000B, 4, 0);
        check_streams("single", 0);
        total++;
        if (vh_g != 4 || rl_g != 4) begin
            bad++;
            $display("FAIL single_counts valid_hi=%0d ready_lo=%0d want 4 4", vh_g, rl_g);
        end
    endtask

    task automatic test_repeat_gap();
        start(16'h000B, 4, 2);
        check_streams("repeat_gap", 0);
        total++;
        if (vh_g != 12 || rl_g != 16) begin
            bad++;
            $display("FAIL repeat_gap_counts valid_hi=%0d ready_lo=%0d want 12 16", vh_g, rl_g);
        end
        total++;
        if (vh_n != 12 || rl_n != 12) begin
            bad++;
            $display("FAIL repeat_nogap_counts valid_hi=%0d ready_lo=%0d want 12 12", vh_n, rl_n);
        end
    endtask

    task automatic test_boundary();
        start(16'h1234, 0, 3);
        check_streams("len0", 0);
        total++;
        if (vh_g != 0 || vh_n != 0) begin
            bad++;
            $display("FAIL len0_valid valid_hi g=%0d n=%0d want 0", vh_g, vh_n);
        end
        start(16'hA5C3, 20, 0);
        check_streams("len20", 0);
        total++;
        if (vh_g != 16) begin
            bad++;
            $display("FAIL len20_count valid_hi=%0d want 16", vh_g);
        end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        d = 16'($urandom) | 16'h0081;
        start(d, 8, 1);
        exp_g.delete();
        exp_n.delete();
        load_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (g_valid !== 1'b1 || g_seq !== d[7-j] || n_valid !== 1'b1 || n_seq !== d[7-j]) begin
                bad++;
                $display("FAIL abort_bit%0d got g=%b%b n=%b%b want valid=1 seq=%b",
                         j, g_valid, g_seq, n_valid, n_seq, d[7-j]);
            end
            if (j < 2) begin
                @(posedge clock);
                #1;
            end
        end
        abort      = 1'b1;
        load_valid = 1'b1;
        load_len   = 5'd4;
        @(posedge clock);
        #1;
        total++;
        if ({g_valid, g_seq, g_done, g_ready} !== 4'b0001 || {n_valid, n_seq, n_done, n_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL abort_exit got g=%b n=%b want=0001",
                     {g_valid, g_seq, g_done, g_ready}, {n_valid, n_seq, n_done, n_ready});
        end
        @(posedge clock);
        #1;
        total++;
        if ({g_valid, g_done, g_ready} !== 3'b001 || {n_valid, n_done, n_ready} !== 3'b001) begin
            bad++;
            $display("FAIL abort_blocks_load got g=%b n=%b want=001",
                     {g_valid, g_done, g_ready}, {n_valid, n_done, n_ready});
        end
        abort      = 1'b0;
        load_valid = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clock);
            #1;
            total++;
            if (g_done !== 1'b0 || g_valid !== 1'b0 || n_done !== 1'b0 || n_valid !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet cyc%0d done g=%b n=%b valid g=%b n=%b want 0",
                         j, g_done, n_done, g_valid, n_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_data   = 16'h000B;
        load_len    = 5'd4;
        load_repeat = 4'd0;
        load_valid  = 1'b1;
        @(posedge clock);
        #1;
        model_push(2, 16'h000B, 4, 0);
        model_push(0, 16'h000B, 4, 0);
        model_push(2, 16'h0006, 3, 0);
        model_push(0, 16'h0006, 3, 0);
        load_data = 16'h0006;
        load_len  = 5'd3;
        check_streams("back_to_back", 5);
        total++;
        if (vh_g != 7) begin
            bad++;
            $display("FAIL back_to_back_count valid_hi=%0d want 7", vh_g);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            start(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
            check_streams("random", 0);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        load_len    = '0;
        load_repeat = '0;
        abort       = 1'b0;
        test_reset();
        test_single();
        test_repeat_gap();
        test_boundary();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_pattern_generator.md
Name: sequence_pattern_generator

Overview:
Serial bit-pattern transmitter. It is the driving end of the serial `sequence_in` line consumed by the team's Moore sequence detector. A pattern word of programmable length is loaded through a valid/ready handshake, then shifted out MSB-first, one bit per clock. The block supports a programmable repeat count and a fixed inter-repetition gap, and pulses `done` on completion.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (width of load_data).
- LEN_W, 5, width of load_len; must satisfy 2^LEN_W > MAX_LEN.
- REP_W, 4, width of load_repeat.
- GAP, 0, number of idle cycles inserted between repetitions (0 = repetitions run back-to-back).
- IDLE_LEVEL, 1'b0, level driven on sequence_out whenever no pattern bit is being sent.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  request to start a pattern.
- load_ready  output  1  high only in IDLE; a load is accepted on an edge where load_valid && load_ready && !abort.
- load_data  input  MAX_LEN  pattern bits; bit [load_len-1] is sent first.
- load_len  input  LEN_W  number of bits per repetition.
- load_repeat  input  REP_W  extra repetitions; the pattern is sent load_repeat+1 times.
- abort  input  1  synchronous cancel.
- sequence_out  output  1  serial data, registered.
- out_valid  output  1  high while sequence_out carries a pattern bit, registered.
- done  output  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - sequence_out = IDLE_LEVEL, out_valid = 0, done = 0, load_ready = 1.
  - Any in-flight pattern is discarded.
- States:
  - IDLE: load_ready = 1, out_valid = 0, sequence_out = IDLE_LEVEL.
  - SHIFT: load_ready = 0, out_valid = 1.
  - GAP: load_ready = 0, out_valid = 0, sequence_out = IDLE_LEVEL.
- Acceptance at edge k:
  - load_data, load_len and load_repeat are captured into internal registers. Later changes to the inputs are ignored.
  - The effective length is min(load_len, MAX_LEN).
- SHIFT timing:
  - After edge k: sequence_out = data[len-1], out_valid = 1.
  - After edge k+i: sequence_out = data[len-1-i].
  - The last bit of a repetition (data[0]) is visible after edge k+len-1.
- End of a repetition:
  - If repetitions remain and GAP > 0: enter GAP for exactly GAP cycles, then SHIFT restarts at data[len-1].
  - If repetitions remain and GAP = 0: SHIFT continues directly at data[len-1], with no bubble.
  - After the last bit of the final repetition (edge k+len for repeat = 0): go to IDLE. done = 1 for exactly one cycle, and load_ready = 1 in that same cycle.
- Back-to-back loads:
  - A new load may be accepted on the edge that ends the done cycle.
  - The result is exactly one non-valid cycle between consecutive patterns.
- load_len = 0:
  - The load is accepted and no bits are sent (out_valid stays 0).
  - done pulses in the cycle after acceptance, regardless of load_repeat.
- load_len > MAX_LEN: clamped to MAX_LEN; load_data[MAX_LEN-1:0] is sent.
- abort:
  - Has priority over everything except reset. From any state, the next edge returns to IDLE with out_valid = 0 and sequence_out = IDLE_LEVEL.
  - done is not asserted on abort.
  - A load presented while abort = 1 is not accepted.
- Counters:
  - The bit index counts down from len-1 to 0.
  - The repeat counter counts down from load_repeat to 0.
  - The gap counter counts from GAP-1 down to 0.
  - None wrap: each counter is reloaded on entry to its state.
- Pattern registers are not cleared on return to IDLE. Only the outputs listed above are defined in IDLE.

Test Plan:
1. Reset: hold reset for 3 cycles, then assert reset asynchronously mid-SHIFT → outputs go to sequence_out = 0, out_valid = 0, done = 0, load_ready = 1 immediately, without waiting for a clock edge.
2. Single pattern: load_data = 16'h000B, load_len = 4, load_repeat = 0 → sequence_out = 1,0,1,1 on 4 consecutive cycles with out_valid = 1, load_ready low for those 4 cycles, then done = 1 for one cycle. Feeding this into the Moore detector asserts detector_out after the 4th bit.
3. Repeat with gap (GAP = 2): load_data = 0xB, load_len = 4, load_repeat = 2 → 1011, 2 idle cycles at 0, 1011, 2 idle cycles, 1011, then done. load_ready is low for 16 cycles and out_valid is high for 12.
4. Boundary lengths: load_len = 0 → no out_valid, done one cycle after acceptance. load_len = 20 with load_data = 16'hA5C3 → exactly 16 bits sent, MSB first: 1010_0101_1100_0011.
5. Abort: start load_len = 8, assert abort after 3 bits → next cycle out_valid = 0 and load_ready = 1, done never pulses. Also change load_data after acceptance on a separate run → transmitted bits are unaffected.
6. Back-to-back: hold load_valid high with two words (0xB/len 4, then 0x6/len 3) → 1011, one cycle with out_valid = 0 and done = 1, then 110 starting on the following cycle.
